// File: rtl/booth_control.sv
// -----------------------------------------------------------------------------
// booth_control
//
// Sequencing FSM for an N_BITS x N_BITS signed Booth multiplier datapath.
// It accepts an operand pair through a start/busy/done handshake, holds the
// operands stable for the datapath, and issues the datapath strobes. The
// strobe order depends on the Booth pair that the datapath feeds back. When
// the datapath result has settled, the FSM captures the final product.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        operation request, sampled only while idle
//   op_a, op_b   signed multiplicand / multiplier, latched on accepted start
//   Qo_Qprev     datapath Booth pair {Q0, Q-1}, PIPE_LAT edges behind strobes
//   mult_result  datapath registered result, PIPE_LAT edges behind strobes
//   num_1, num_2 latched operands driven to the datapath
//   load_M       multiplicand load strobe (asserted together with load_Q)
//   load_Q       multiplier load strobe
//   load_add     add/sub writeback strobe
//   shift_all    arithmetic shift strobe
//   dp_clear     one-cycle datapath clear request
//   busy         high in every state except IDLE
//   done         registered one-cycle pulse, product valid
//   product      signed product, held until the next done
// -----------------------------------------------------------------------------
module booth_control #(
    parameter int N_BITS   = 8,
    parameter int PIPE_LAT = 2      // must be >= 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N_BITS-1:0]     op_a,
    input  logic [N_BITS-1:0]     op_b,
    input  logic [1:0]            Qo_Qprev,
    input  logic [2*N_BITS-1:0]   mult_result,
    output logic [N_BITS-1:0]     num_1,
    output logic [N_BITS-1:0]     num_2,
    output logic                  load_M,
    output logic                  load_Q,
    output logic                  load_add,
    output logic                  shift_all,
    output logic                  dp_clear,
    output logic                  busy,
    output logic                  done,
    output logic [2*N_BITS-1:0]   product
);

    // The iteration counter has one spare bit so that the terminal count
    // never wraps.
    localparam int ITER_W = $clog2(N_BITS) + 1;
    localparam int CNT_W  = $clog2(PIPE_LAT + 1);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_BITS - 1);
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(PIPE_LAT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CLEAR = 4'd1,
        ST_LOAD  = 4'd2,
        ST_WAIT  = 4'd3,
        ST_EVAL  = 4'd4,
        ST_ADD   = 4'd5,
        ST_SHIFT = 4'd6,
        ST_FLUSH = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    state_t                 state_reg,   state_next;
    logic [ITER_W-1:0]      iter_reg,    iter_next;
    logic [CNT_W-1:0]       cnt_reg,     cnt_next;
    logic [N_BITS-1:0]      num_1_reg,   num_1_next;
    logic [N_BITS-1:0]      num_2_reg,   num_2_next;
    logic [2*N_BITS-1:0]    product_reg, product_next;
    logic                   done_reg,    done_next;

    // -------------------------------------------------------------------------
    // State and data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            iter_reg    <= '0;
            cnt_reg     <= '0;
            num_1_reg   <= '0;
            num_2_reg   <= '0;
            product_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            iter_reg    <= iter_next;
            cnt_reg     <= cnt_next;
            num_1_reg   <= num_1_next;
            num_2_reg   <= num_2_next;
            product_reg <= product_next;
            done_reg    <= done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and Moore strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        iter_next    = iter_reg;
        cnt_next     = cnt_reg;
        num_1_next   = num_1_reg;
        num_2_next   = num_2_reg;
        product_next = product_reg;
        done_next    = 1'b0;

        load_M       = 1'b0;
        load_Q       = 1'b0;
        load_add     = 1'b0;
        shift_all    = 1'b0;
        dp_clear     = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    num_1_next = op_a;
                    num_2_next = op_b;
                    iter_next  = '0;
                    state_next = ST_CLEAR;
                end
            end

            // Clearing first removes any leftover Q-1 bit or high half from
            // the previous product.
            ST_CLEAR: begin
                dp_clear   = 1'b1;
                state_next = ST_LOAD;
            end

            ST_LOAD: begin
                load_M     = 1'b1;
                load_Q     = 1'b1;
                cnt_next   = CNT_LOAD;
                state_next = ST_WAIT;
            end

            // Let the last load/shift reach Qo_Qprev before it is sampled.
            ST_WAIT: begin
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    state_next = ST_EVAL;
                end
            end

            // 01 -> add M, 10 -> subtract M; the datapath decides which from
            // the same pair, so the controller only needs to know "not equal".
            ST_EVAL: begin
                if (Qo_Qprev[1] ^ Qo_Qprev[0]) begin
                    state_next = ST_ADD;
                end else begin
                    state_next = ST_SHIFT;
                end
            end

            ST_ADD: begin
                load_add   = 1'b1;
                state_next = ST_SHIFT;
            end

            ST_SHIFT: begin
                shift_all = 1'b1;
                iter_next = iter_reg + ITER_ONE;
                cnt_next  = CNT_LOAD;
                if (iter_reg == LAST_ITER) begin
                    state_next = ST_FLUSH;
                end else begin
                    state_next = ST_WAIT;
                end
            end

            // Let the final shift reach mult_result.
            ST_FLUSH: begin
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                product_next = mult_result;
                done_next    = 1'b1;
                state_next   = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign product = product_reg;
    assign num_1   = num_1_reg;
    assign num_2   = num_2_reg;

endmodule

// File: tb/tb_booth_control.sv
module tb_booth_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  op_a = 8'h00;
    logic [7:0]  op_b = 8'h00;
    logic [1:0]  Qo_Qprev;
    logic [15:0] mult_result;
    logic [7:0]  num_1, num_2;
    logic        load_M, load_Q, load_add, shift_all, dp_clear, busy, done;
    logic [15:0] product;

    always #5 clk = ~clk;

    booth_control #(.N_BITS(8), .PIPE_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .Qo_Qprev(Qo_Qprev), .mult_result(mult_result),
        .num_1(num_1), .num_2(num_2), .load_M(load_M), .load_Q(load_Q),
        .load_add(load_add), .shift_all(shift_all), .dp_clear(dp_clear),
        .busy(busy), .done(done), .product(product)
    );

    // ---------------- behavioural Booth datapath (two-edge latency) ----------
    logic signed [8:0] acc;
    logic [7:0]        mm, mq;
    logic              qm1;
    logic [1:0]        qq_r;
    logic [15:0]       res_r;

    always @(posedge clk or posedge reset) begin
        if (reset || dp_clear) begin
            acc <= '0; mm <= '0; mq <= '0; qm1 <= 1'b0;
        end else begin
            if (load_M) mm <= num_1;
            if (load_Q) begin mq <= num_2; qm1 <= 1'b0; end
            if (load_add) begin
                if ({mq[0], qm1} == 2'b01) acc <= acc + {mm[7], mm};
                else if ({mq[0], qm1} == 2'b10) acc <= acc - {mm[7], mm};
            end
            if (shift_all) {acc, mq, qm1} <= {acc[8], acc, mq};
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qq_r <= '0; res_r <= '0;
        end else begin
            qq_r  <= {mq[0], qm1};
            res_r <= {acc[7:0], mq};
        end
    end
    assign Qo_Qprev    = qq_r;
    assign mult_result = res_r;

    // ---------------- bookkeeping ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int viol_cnt = 0;
    int done_cnt = 0;
    int add_cnt = 0;

    typedef struct {
        logic [15:0] prod;
        int          adds;
        int          lat;
        int          start_edge;
    } item_t;
    item_t sb[$];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        int n;
        item_t it;
        if (reset) begin
            add_cnt = 0;
        end else begin
            n = int'(load_M) + int'(load_Q) + int'(load_add) + int'(shift_all) + int'(dp_clear);
            if ((load_M != load_Q) || (n > 1 && !(load_M && load_Q && n == 2))) viol_cnt++;
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: got product %h expected no done", product);
                end else begin
                    it = sb.pop_front();
                    $display("done: product=%h adds=%0d latency=%0d", product, add_cnt, cyc - it.start_edge);
                    chk("product", 40'(product), 40'(it.prod));
                    chk("add_pulses", 40'(add_cnt), 40'(it.adds));
                    chk("latency", 40'(cyc - it.start_edge), 40'(it.lat));
                end
                add_cnt = 0;
            end else if (load_add) begin
                add_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] prod, input int adds);
        item_t it;
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        it.prod = prod; it.adds = adds; it.lat = 37 + adds; it.start_edge = cyc;
        sb.push_back(it);
        $display("start: op_a=%h op_b=%h expect=%h", a, b, prod);
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) return;
        end
        chk({name, "_timeout"}, 40'd0, 40'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int bad;
        int shifts;
        logic ok;

        // reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",
            {1'b0, num_1, num_2, product, load_M, load_Q, load_add, shift_all, dp_clear, busy, done},
            40'd0);
        @(negedge clk); reset = 1'b0;
        idle_cycles(2);

        // 3 * 5: 4 adds, done on edge 41, busy on edges 1..40
        issue(8'd3, 8'd5, 16'h000F, 4);
        bad = 0;
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk); #1;
            if (busy !== (k <= 40)) bad++;
        end
        chk("busy_window", 40'(bad), 40'd0);
        idle_cycles(3);

        // -7 * 6 = -42
        issue(8'hF9, 8'd6, 16'hFFD6, 2);
        wait_done("neg_mul", 100);
        idle_cycles(2);

        // -128 * -128, then start in the done cycle: 0x25 * 0
        issue(8'h80, 8'h80, 16'h4000, 1);
        wait_done("min_mul", 100);
        issue(8'h25, 8'h00, 16'h0000, 0);
        chk("busy_after_back2back", 40'(busy), 40'd1);
        wait_done("zero_mul", 100);
        idle_cycles(2);

        // start while busy is ignored; operands held
        issue(8'd9, 8'd10, 16'h005A, 4);
        repeat (9) @(posedge clk);
        #1;
        op_a = 8'h11; op_b = 8'h22; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("num_hold_busy", 40'({num_1, num_2}), 40'h090A);
        wait_done("ignore_start", 100);
        chk("num_hold_done", 40'({num_1, num_2}), 40'h090A);
        idle_cycles(60);

        // reset during the 5th SHIFT
        issue(8'd5, 8'd3, 16'h000F, 2);
        shifts = 0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            if (shift_all) shifts++;
            if (shifts == 5) ok = 1'b1;
        end
        if (!ok) chk("fifth_shift_timeout", 40'd0, 40'd1);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("reset_mid_op",
            {1'b0, num_1, num_2, product, load_M, load_Q, load_add, shift_all, dp_clear, busy, done},
            40'd0);
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        idle_cycles(60);

        // 2 * -1 after the aborted operation
        issue(8'd2, 8'hFF, 16'hFFFE, 1);
        wait_done("after_reset", 100);
        idle_cycles(5);

        chk("strobe_overlap", 40'(viol_cnt), 40'd0);
        chk("done_count", 40'(done_cnt), 40'd6);
        chk("queue_empty", 40'(sb.size()), 40'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/booth_control.md
Name: booth_control

Overview:
- Sequencing FSM that drives the 8x8 signed Booth multiplier datapath. It sits directly upstream of that datapath.
- Accepts an operand pair through a start/busy/done handshake and holds the operands stable on num_1/num_2.
- Pulses load_M/load_Q/load_add/shift_all according to the datapath's Qo_Qprev feedback.
- Captures the final 16-bit product when the datapath's registered result has settled.

Parameters:
N_BITS, 8, number of Booth iterations (operand width).
PIPE_LAT, 2, clock edges between a datapath shift/load and Qo_Qprev/mult_result reflecting it.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
op_a  in  8  signed multiplicand; latched on accepted start
op_b  in  8  signed multiplier; latched on accepted start
Qo_Qprev  in  2  datapath Booth pair {Q0, Q-1}
mult_result  in  16  datapath registered result
num_1  out  8  latched op_a to datapath
num_2  out  8  latched op_b to datapath
load_M  out  1  datapath multiplicand load strobe
load_Q  out  1  datapath multiplier load strobe
load_add  out  1  datapath add/sub writeback strobe
shift_all  out  1  datapath arithmetic shift strobe
dp_clear  out  1  one-cycle datapath clear request; top level maps it onto the datapath reset
busy  out  1  high in every state except IDLE
done  out  1  registered one-cycle pulse, product valid
product  out  16  signed product; held until next done

Behaviour:
- Reset (async, active-high): state=IDLE; iter=0; wait counter=0; every output 0, including num_1, num_2 and product.
- States: IDLE, CLEAR, LOAD, WAIT, EVAL, ADD, SHIFT, FLUSH, DONE. Exactly one strobe is high per cycle, and only in the listed state.
- IDLE: if start=1 at an edge, latch op_a→num_1 and op_b→num_2, clear iter, go to CLEAR. Otherwise stay.
- CLEAR (1 cycle): dp_clear=1. Go to LOAD.
- LOAD (1 cycle): load_M=1 and load_Q=1 together; this is the only two-strobe cycle. Load wait counter=PIPE_LAT, go to WAIT.
- WAIT: no strobes; decrement counter; go to EVAL when it reaches 0. Lasts exactly PIPE_LAT cycles.
- EVAL (1 cycle): sample Qo_Qprev. Value 01 or 10 goes to ADD; 00 or 11 goes to SHIFT.
- ADD (1 cycle): load_add=1. Go to SHIFT.
- SHIFT (1 cycle): shift_all=1; iter<=iter+1.
  - If iter==N_BITS-1 before increment: load counter=PIPE_LAT, go to FLUSH.
  - Else: load counter=PIPE_LAT, go to WAIT.
- FLUSH: no strobes; lasts PIPE_LAT cycles, then DONE.
- DONE (1 cycle): mult_result is valid during this cycle. On the exiting edge: product<=mult_result, done<=1, state<=IDLE.
- done is cleared on the following edge. busy is 0 in the done cycle.
- Iteration cost: PIPE_LAT+2 cycles (no add) or PIPE_LAT+3 cycles (add).
- Latency with defaults: done rises on edge 5+32+A after the start-sampling edge, where A = number of ADD visits.
- start while busy: ignored; num_1/num_2 stay stable for the whole operation.
- start high in the done cycle: accepted, since the state is IDLE.
- Reset mid-operation: immediate return to reset values. The partial result is discarded and done is not asserted.
- iter is a 4-bit counter (ceil(log2(N_BITS))+1 bits). It never wraps, because the N_BITS check terminates the loop.
- op_a/op_b changes after acceptance have no effect.

Test Plan:
- reset high, then start with op_a=3, op_b=5 → exactly 4 load_add pulses; done on edge 41 after start; product=0x000F; busy high edges 1..40.
- op_a=-7 (0xF9), op_b=6 → product=0xFFD6 (-42); one done pulse; strobes never overlap except load_M+load_Q in LOAD.
- op_a=-128, op_b=-128 → product=0x4000.
  - Then immediate start with op_a=0x25, op_b=0x00 → zero load_add pulses; done 37 edges after start; product=0x0000 (checks dp_clear removes residual Q-1/high half).
- start asserted at edge 10 of a running multiply with different operands → ignored; num_1/num_2 unchanged; first product correct; no second done.
- reset pulsed during the 5th SHIFT → all outputs 0 immediately, state IDLE, no done.
  - A following start with op_a=2, op_b=-1 → product=0xFFFE.
